// File: rtl/note_pkg.sv
// Shared constants and saturation helpers for the polyphonic note generator.
package note_pkg;

  localparam int unsigned DefNumCh    = 2;
  localparam int unsigned DefCntW     = 22;
  localparam int unsigned DefAmpW     = 16;
  localparam int unsigned DefRampDiv  = 1024;
  localparam int unsigned DefRampStep = 32'h0040;

  // Largest positive value of an amp_w-bit two's-complement sample.
  function automatic longint sat_max(int unsigned amp_w);
    return (longint'(1) <<< (amp_w - 1)) - 1;
  endfunction

  // Most negative value of an amp_w-bit two's-complement sample.
  function automatic longint sat_min(int unsigned amp_w);
    return -(longint'(1) <<< (amp_w - 1));
  endfunction

endpackage

// File: rtl/poly_note_generator_if.sv
// Control inputs and audio outputs of the note generator, bundled as one bus.
interface poly_note_generator_if
  import note_pkg::*;
#(
  parameter int unsigned NUM_CH = DefNumCh,
  parameter int unsigned CNT_W  = DefCntW,
  parameter int unsigned AMP_W  = DefAmpW
);

  logic                      start;
  logic [NUM_CH-1:0]         ch_en;
  logic [NUM_CH*CNT_W-1:0]   pitch;
  logic [NUM_CH*AMP_W-1:0]   amp;
  logic [NUM_CH-1:0]         pan_l;
  logic [NUM_CH-1:0]         pan_r;
  logic [AMP_W-1:0]          audio_left;
  logic [AMP_W-1:0]          audio_right;
  logic [NUM_CH-1:0]         active;

  // Controller side: drives note settings, observes audio.
  modport master (
    output start, ch_en, pitch, amp, pan_l, pan_r,
    input  audio_left, audio_right, active
  );

  // Generator side.
  modport slave (
    input  start, ch_en, pitch, amp, pan_l, pan_r,
    output audio_left, audio_right, active
  );

endinterface

// File: rtl/note_channel.sv
// One tone channel: square-wave half-period divider, boundary-latched pitch,
// and a linear envelope that steps toward its target on prescaler ticks.
module note_channel
  import note_pkg::*;
#(
  parameter int unsigned CNT_W     = DefCntW,
  parameter int unsigned AMP_W     = DefAmpW,
  parameter int unsigned RAMP_STEP = DefRampStep
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick_i,
  input  logic                    play_i,
  input  logic [CNT_W-1:0]        pitch_i,
  input  logic [AMP_W-1:0]        amp_i,
  output logic signed [AMP_W-1:0] sample_o,
  output logic                    active_o
);

  localparam logic [AMP_W-1:0] AmpMax   = AMP_W'(sat_max(AMP_W));
  // A step larger than the full range behaves like a full-range jump.
  localparam int unsigned      StepLim  = 1 << AMP_W;
  localparam logic [AMP_W:0]   Step     = (AMP_W+1)'((RAMP_STEP > StepLim) ? StepLim : RAMP_STEP);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pitch_q, pitch_d;
  logic             phase_q, phase_d;
  logic [AMP_W-1:0] env_q, env_d;
  logic             active_q;
  logic [AMP_W-1:0] target;
  logic             rest;
  logic             boundary;
  logic [AMP_W:0]   env_w, tgt_w, up_w, dn_w, diff_w;

  assign rest     = (pitch_q == '0);
  assign boundary = !rest && (cnt_q == pitch_q);

  // Divider: a new pitch is only accepted at a half-period boundary or while resting.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    pitch_d = pitch_q;
    if (rest) begin
      pitch_d = pitch_i;
    end else if (boundary) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
      pitch_d = pitch_i;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Envelope target: clamped amplitude while playing a non-rest pitch, else silence.
  always_comb begin
    target = '0;
    if (play_i && !rest) begin
      target = (amp_i > AmpMax) ? AmpMax : amp_i;
    end
  end

  // Envelope ramp: one step toward target per tick, landing exactly on it.
  always_comb begin
    env_w  = {1'b0, env_q};
    tgt_w  = {1'b0, target};
    up_w   = env_w + Step;
    dn_w   = env_w - Step;
    diff_w = env_w - tgt_w;
    env_d  = env_q;
    if (tick_i) begin
      if (env_w < tgt_w) begin
        env_d = (up_w >= tgt_w) ? target : up_w[AMP_W-1:0];
      end else if (env_w > tgt_w) begin
        env_d = (diff_w <= Step) ? target : dn_w[AMP_W-1:0];
      end
    end
  end

  // Channel state registers; active tracks the envelope register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      pitch_q  <= '0;
      phase_q  <= 1'b0;
      env_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pitch_q  <= pitch_d;
      phase_q  <= phase_d;
      env_q    <= env_d;
      active_q <= (env_d != '0);
    end
  end

  assign sample_o = phase_q ? -$signed(env_q) : $signed(env_q);
  assign active_o = active_q;

endmodule

// File: rtl/poly_note_generator.sv
// Polyphonic square-wave generator: NUM_CH channels, a shared envelope
// prescaler, and a saturating stereo mixer with registered outputs.
module poly_note_generator
  import note_pkg::*;
#(
  parameter int unsigned NUM_CH    = DefNumCh,
  parameter int unsigned CNT_W     = DefCntW,
  parameter int unsigned AMP_W     = DefAmpW,
  parameter int unsigned RAMP_DIV  = DefRampDiv,
  parameter int unsigned RAMP_STEP = DefRampStep
) (
  input logic                  clk,
  input logic                  rst_n,
  poly_note_generator_if.slave bus
);

  localparam int unsigned PreW    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(RAMP_DIV - 1);
  // Wide enough to hold every channel at full scale without wrapping.
  localparam int unsigned SumW    = AMP_W + $clog2(NUM_CH) + 1;
  localparam logic signed [SumW-1:0] SatHi = SumW'(sat_max(AMP_W));
  localparam logic signed [SumW-1:0] SatLo = SumW'(sat_min(AMP_W));

  logic [PreW-1:0]          pre_q, pre_d;
  logic                     tick;
  logic signed [AMP_W-1:0]  sample [NUM_CH];
  logic [NUM_CH-1:0]        active;
  logic signed [SumW-1:0]   sum_l, sum_r;
  logic signed [AMP_W-1:0]  audio_left_q, audio_left_d;
  logic signed [AMP_W-1:0]  audio_right_q, audio_right_d;

  assign tick = (pre_q == PreLast);

  // Prescaler: wraps every RAMP_DIV cycles, ticking on the last count.
  always_comb begin
    pre_d = tick ? '0 : pre_q + PreW'(1);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    note_channel #(
      .CNT_W     (CNT_W),
      .AMP_W     (AMP_W),
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_i   (tick),
      .play_i   (bus.start & bus.ch_en[i]),
      .pitch_i  (bus.pitch[i*CNT_W +: CNT_W]),
      .amp_i    (bus.amp[i*AMP_W +: AMP_W]),
      .sample_o (sample[i]),
      .active_o (active[i])
    );
  end

  // Mixer: sum panned samples at full width, then saturate to the sample range.
  always_comb begin
    sum_l = '0;
    sum_r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.pan_l[i]) sum_l = sum_l + SumW'(sample[i]);
      if (bus.pan_r[i]) sum_r = sum_r + SumW'(sample[i]);
    end
    audio_left_d  = (sum_l > SatHi) ? AMP_W'(SatHi) :
                    (sum_l < SatLo) ? AMP_W'(SatLo) : sum_l[AMP_W-1:0];
    audio_right_d = (sum_r > SatHi) ? AMP_W'(SatHi) :
                    (sum_r < SatLo) ? AMP_W'(SatLo) : sum_r[AMP_W-1:0];
  end

  // Prescaler and output sample registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q         <= '0;
      audio_left_q  <= '0;
      audio_right_q <= '0;
    end else begin
      pre_q         <= pre_d;
      audio_left_q  <= audio_left_d;
      audio_right_q <= audio_right_d;
    end
  end

  assign bus.audio_left  = audio_left_q;
  assign bus.audio_right = audio_right_q;
  assign bus.active      = active;

endmodule

// File: tb/tb_poly_note_generator.sv
// Scoreboard bench: two generators (instant and slow envelopes) share one
// randomized stimulus stream; a reference model predicts each cycle's outputs.
module tb_poly_note_generator;
  import note_pkg::*;

  localparam int NCH    = 2;
  localparam int CW     = 22;
  localparam int AW     = 16;
  localparam int DIV_A  = 1;
  localparam int STEP_A = 32'h7FFF;
  localparam int DIV_B  = 4;
  localparam int STEP_B = 32'h1000;

  typedef struct {
    int la; int ra; int aa;
    int lb; int rb; int ab;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  poly_note_generator_if #(.NUM_CH(NCH), .CNT_W(CW), .AMP_W(AW)) bus_a ();
  poly_note_generator_if #(.NUM_CH(NCH), .CNT_W(CW), .AMP_W(AW)) bus_b ();

  assign bus_b.start = bus_a.start;
  assign bus_b.ch_en = bus_a.ch_en;
  assign bus_b.pitch = bus_a.pitch;
  assign bus_b.amp   = bus_a.amp;
  assign bus_b.pan_l = bus_a.pan_l;
  assign bus_b.pan_r = bus_a.pan_r;

  poly_note_generator #(
    .NUM_CH(NCH), .CNT_W(CW), .AMP_W(AW), .RAMP_DIV(DIV_A), .RAMP_STEP(STEP_A)
  ) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  poly_note_generator #(
    .NUM_CH(NCH), .CNT_W(CW), .AMP_W(AW), .RAMP_DIV(DIV_B), .RAMP_STEP(STEP_B)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // Stimulus settings.
  bit s_start;
  bit s_en   [NCH];
  int s_pitch[NCH];
  int s_amp  [NCH];
  bit s_panl [NCH];
  bit s_panr [NCH];

  // Reference model: per instance/channel sign, cycles left in the half-period,
  // latched half-period length, and envelope level; plus edge count since reset.
  int m_neg [2][NCH];
  int m_left[2][NCH];
  int m_len [2][NCH];
  int m_env [2][NCH];
  int m_edge[2];

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_edge[k] = 0;
      for (int c = 0; c < NCH; c++) begin
        m_neg[k][c] = 0; m_left[k][c] = 0; m_len[k][c] = 0; m_env[k][c] = 0;
      end
    end
  endtask

  // Advance instance k by one clock edge; returns outputs visible after the edge.
  task automatic model_step(input int k, input int div, input int step,
                            output int el, output int er, output int ea);
    int sl, sr, s, t;
    bit tick;
    sl = 0; sr = 0; ea = 0;
    for (int c = 0; c < NCH; c++) begin
      s = m_neg[k][c] ? -m_env[k][c] : m_env[k][c];
      if (s_panl[c]) sl += s;
      if (s_panr[c]) sr += s;
    end
    el = sat(sl);
    er = sat(sr);
    tick = ((m_edge[k] % div) == div - 1);
    m_edge[k]++;
    for (int c = 0; c < NCH; c++) begin
      t = (s_start && s_en[c] && m_len[k][c] != 0) ? ((s_amp[c] > 32767) ? 32767 : s_amp[c]) : 0;
      if (tick) begin
        if (m_env[k][c] < t) m_env[k][c] = (m_env[k][c] + step > t) ? t : m_env[k][c] + step;
        else if (m_env[k][c] > t) m_env[k][c] = (m_env[k][c] - step < t) ? t : m_env[k][c] - step;
      end
      if (m_len[k][c] == 0) begin
        m_len[k][c]  = s_pitch[c];
        m_left[k][c] = s_pitch[c];
      end else if (m_left[k][c] == 0) begin
        m_neg[k][c]  = 1 - m_neg[k][c];
        m_len[k][c]  = s_pitch[c];
        m_left[k][c] = s_pitch[c];
      end else begin
        m_left[k][c]--;
      end
      if (m_env[k][c] != 0) ea |= (1 << c);
    end
  endtask

  task automatic drive();
    logic [NCH*CW-1:0] pv;
    logic [NCH*AW-1:0] av;
    for (int c = 0; c < NCH; c++) begin
      pv[c*CW +: CW]  = CW'(s_pitch[c]);
      av[c*AW +: AW]  = AW'(s_amp[c]);
      bus_a.ch_en[c]  = s_en[c];
      bus_a.pan_l[c]  = s_panl[c];
      bus_a.pan_r[c]  = s_panr[c];
    end
    bus_a.start = s_start;
    bus_a.pitch = pv;
    bus_a.amp   = av;
  endtask

  task automatic push_zero();
    exp_t e;
    e = '{la: 0, ra: 0, aa: 0, lb: 0, rb: 0, ab: 0};
    sb.push_back(e);
  endtask

  // One stimulus cycle: apply inputs at the falling edge and predict the next rising edge.
  task automatic cycle(input bit rst_v);
    exp_t e;
    @(negedge clk);
    rst_n = rst_v;
    drive();
    if (!rst_v) begin
      model_reset();
      push_zero();
    end else begin
      model_step(0, DIV_A, STEP_A, e.la, e.ra, e.aa);
      model_step(1, DIV_B, STEP_B, e.lb, e.rb, e.ab);
      sb.push_back(e);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1);
  endtask

  // Asynchronous reset between edges: outputs must clear at once.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_a_left",   int'($signed(bus_a.audio_left)),  0);
    chk("rst_a_right",  int'($signed(bus_a.audio_right)), 0);
    chk("rst_a_active", int'(bus_a.active),               0);
    chk("rst_b_left",   int'($signed(bus_b.audio_left)),  0);
    chk("rst_b_right",  int'($signed(bus_b.audio_right)), 0);
    chk("rst_b_active", int'(bus_b.active),               0);
    model_reset();
    push_zero();
    cycle(1'b0);
    cycle(1'b0);
  endtask

  task automatic set_ch(input int c, input bit en, input int p, input int a, input bit pl,
                        input bit pr);
    s_en[c] = en; s_pitch[c] = p; s_amp[c] = a; s_panl[c] = pl; s_panr[c] = pr;
  endtask

  // Monitor: compare every registered output sample against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("a_left",   int'($signed(bus_a.audio_left)),  e.la);
        chk("a_right",  int'($signed(bus_a.audio_right)), e.ra);
        chk("a_active", int'(bus_a.active),               e.aa);
        chk("b_left",   int'($signed(bus_b.audio_left)),  e.lb);
        chk("b_right",  int'($signed(bus_b.audio_right)), e.rb);
        chk("b_active", int'(bus_b.active),               e.ab);
      end
    end
  end

  initial begin
    s_start = 1'b0;
    for (int c = 0; c < NCH; c++) set_ch(c, 1'b0, 0, 0, 1'b0, 1'b0);
    drive();
    model_reset();
    cycle(1'b0);
    cycle(1'b0);

    // Single channel tone to the left only.
    s_start = 1'b1;
    set_ch(0, 1'b1, 3, 16'h7FFF, 1'b1, 1'b0);
    run(30);

    // Both channels in phase on both sides: mixer saturates.
    set_ch(1, 1'b1, 3, 16'h7FFF, 1'b1, 1'b1);
    set_ch(0, 1'b1, 3, 16'h7FFF, 1'b1, 1'b1);
    cycle(1'b0);
    cycle(1'b0);
    run(30);

    // Pitch change lands only at the next half-period boundary.
    set_ch(1, 1'b0, 0, 0, 1'b0, 1'b0);
    run(2);
    s_pitch[0] = 9;
    run(40);

    // Global fade-out while the divider keeps running.
    s_start = 1'b0;
    run(40);
    s_start = 1'b1;
    run(20);

    // Rest: divider freezes, envelope decays.
    s_pitch[0] = 0;
    run(30);

    // Randomized segments with an asynchronous reset part way through.
    for (int seg = 0; seg < 60; seg++) begin
      s_start = ($urandom_range(0, 4) != 0);
      for (int c = 0; c < NCH; c++) begin
        set_ch(c, ($urandom_range(0, 4) != 0),
               ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12)),
               int'($urandom_range(0, 65535)), 1'($urandom), 1'($urandom));
      end
      if (seg == 30) mid_reset();
      run(int'($urandom_range(5, 40)));
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
